// File: rtl/tt_mul_pkg.sv
// rtl/tt_mul_pkg.sv - shared constants and FSM state type for the multiplier operand loader
package tt_mul_pkg;

  // Default operand width; operands are assembled one byte at a time
  localparam int WIDTH_DEFAULT = 32;

  // Loader FSM states; the encoding is visible on the debug pins
  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    ISSUE  = 2'd2
  } state_t;

  // Number of bytes making up one operand of the given width
  function automatic int bytes_of(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/pin_sync_edge.sv
// rtl/pin_sync_edge.sv - multi-flop pin synchroniser with registered rising-edge pulse
module pin_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              level_d;

  // Shift the pin through the synchroniser and register a one-cycle pulse on 0->1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_d <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], din};
      level_d <= sync_q[STAGES-1];
      rise    <= sync_q[STAGES-1] & ~level_d;
    end
  end

  assign level = sync_q[STAGES-1];

endmodule

// File: rtl/mul_operand_loader.sv
// rtl/mul_operand_loader.sv - assembles two operands from strobed pin bytes and issues them with valid/ready
module mul_operand_loader
  import tt_mul_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [7:0]       byte_in,
  input  logic             byte_stb,
  input  logic             clr,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [1:0]       state_o,
  output logic [1:0]       byte_idx,
  output logic             overrun
);

  // byte_idx is a 2-bit debug port, so operands hold at most four bytes
  localparam int         BYTES     = bytes_of(WIDTH);
  localparam logic [1:0] LAST_BYTE = 2'(BYTES - 1);

  logic       stb_evt;
  logic       clr_sync;
  logic       clr_rise_unused;
  logic [7:0] byte_pipe [SYNC_STAGES];
  logic [7:0] byte_sync;

  state_t           state_q, state_n;
  logic [1:0]       idx_q, idx_n;
  logic [WIDTH-1:0] op_a_n, op_b_n;
  logic             valid_n, overrun_n;

  pin_sync_edge #(.STAGES(SYNC_STAGES)) u_stb_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (byte_stb),
    .level (),
    .rise  (stb_evt)
  );

  pin_sync_edge #(.STAGES(SYNC_STAGES)) u_clr_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (clr),
    .level (clr_sync),
    .rise  (clr_rise_unused)
  );

  // Delay the data byte by the synchroniser depth so it lines up with the strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) byte_pipe[i] <= 8'h00;
    end else begin
      byte_pipe[0] <= byte_in;
      for (int i = 1; i < SYNC_STAGES; i++) byte_pipe[i] <= byte_pipe[i-1];
    end
  end

  assign byte_sync = byte_pipe[SYNC_STAGES-1];

  // FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOAD_A;
      idx_q    <= 2'd0;
      op_a     <= '0;
      op_b     <= '0;
      op_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state_q  <= state_n;
      idx_q    <= idx_n;
      op_a     <= op_a_n;
      op_b     <= op_b_n;
      op_valid <= valid_n;
      overrun  <= overrun_n;
    end
  end

  // Next-state logic: clear beats enable, enable gates all FSM activity
  always_comb begin
    state_n   = state_q;
    idx_n     = idx_q;
    op_a_n    = op_a;
    op_b_n    = op_b;
    valid_n   = op_valid;
    overrun_n = overrun;
    if (clr_sync) begin
      state_n   = LOAD_A;
      idx_n     = 2'd0;
      valid_n   = 1'b0;
      overrun_n = 1'b0;
    end else if (ena) begin
      case (state_q)
        LOAD_A: begin
          if (stb_evt) begin
            op_a_n[8*idx_q +: 8] = byte_sync;
            if (idx_q == LAST_BYTE) begin
              idx_n   = 2'd0;
              state_n = LOAD_B;
            end else begin
              idx_n = idx_q + 2'd1;
            end
          end
        end
        LOAD_B: begin
          if (stb_evt) begin
            op_b_n[8*idx_q +: 8] = byte_sync;
            if (idx_q == LAST_BYTE) begin
              idx_n   = 2'd0;
              state_n = ISSUE;
              valid_n = 1'b1;
            end else begin
              idx_n = idx_q + 2'd1;
            end
          end
        end
        ISSUE: begin
          // Operands are frozen; any byte arriving now is dropped and flagged
          if (stb_evt) overrun_n = 1'b1;
          if (op_valid && op_ready) begin
            valid_n = 1'b0;
            state_n = LOAD_A;
            idx_n   = 2'd0;
          end
        end
        default: begin
          state_n = LOAD_A;
          idx_n   = 2'd0;
          valid_n = 1'b0;
        end
      endcase
    end
  end

  assign state_o  = state_q;
  assign byte_idx = idx_q;

endmodule

// File: tb/tb_mul_operand_loader.sv
// tb/tb_mul_operand_loader.sv - scoreboard bench for the multiplier operand loader
module tb_mul_operand_loader;

  localparam int WIDTH = 32;
  localparam int SYNC  = 2;
  localparam int NB    = WIDTH / 8;

  logic             clk = 1'b0;
  logic             rst_n, ena, byte_stb, clr, op_ready;
  logic [7:0]       byte_in;
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_valid, overrun;
  logic [1:0]       state_o, byte_idx;

  int total = 0;
  int bad   = 0;
  logic [2*WIDTH-1:0] exp_q [$];

  mul_operand_loader #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .byte_in  (byte_in),
    .byte_stb (byte_stb),
    .clr      (clr),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .state_o  (state_o),
    .byte_idx (byte_idx),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_slow(input logic [7:0] b);
    byte_in = b;
    tick(1);
    byte_stb = 1'b1;
    tick(3);
    byte_stb = 1'b0;
    tick(2);
  endtask

  task automatic send_pair_slow(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    for (int i = 0; i < NB; i++) send_slow(a[8*i +: 8]);
    for (int i = 0; i < NB; i++) send_slow(b[8*i +: 8]);
  endtask

  // Strobes at the minimum spacing: high 2 clk, low 2 clk, data changes on the falling strobe
  task automatic send_pair_fast(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] bytes;
    bytes = {b, a};
    byte_in = bytes[7:0];
    tick(1);
    for (int i = 0; i < 2*NB; i++) begin
      byte_stb = 1'b1;
      tick(2);
      byte_stb = 1'b0;
      if (i < 2*NB-1) byte_in = bytes[8*(i+1) +: 8];
      tick(2);
    end
  endtask

  task automatic wait_handshake();
    int budget;
    budget = 0;
    while (op_valid === 1'b1 && budget < 100) begin
      op_ready = 1'($urandom_range(0, 1));
      tick(1);
      budget++;
    end
    op_ready = 1'b0;
    if (budget >= 100) chk("handshake_timeout", 1, 0);
  endtask

  // Monitor: every accepted pair must match the oldest expected pair
  always @(negedge clk) begin
    if (rst_n && ena && !clr && op_valid && op_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pair", {op_a, op_b}, 64'h0);
      end else begin
        chk("pair", {op_a, op_b}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] ra, rb;
    rst_n = 1'b0; ena = 1'b1; byte_in = 8'h00; byte_stb = 1'b0; clr = 1'b0; op_ready = 1'b0;
    tick(3);
    chk("rst_valid", op_valid, 0);
    chk("rst_op_a", op_a, 0);
    chk("rst_op_b", op_b, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_idx", byte_idx, 0);
    chk("rst_state", state_o, 0);
    rst_n = 1'b1;
    tick(2);

    // Reset in the middle of loading A
    send_slow(8'h11); send_slow(8'h22); send_slow(8'h33);
    chk("midload_idx", byte_idx, 3);
    chk("midload_op_a", op_a, 32'h00332211);
    rst_n = 1'b0;
    #1;
    chk("midrst_op_a", op_a, 0);
    chk("midrst_idx", byte_idx, 0);
    chk("midrst_state", state_o, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Directed pair with exact latency on the final strobe
    exp_q.push_back({32'h12345678, 32'h0000FFFF});
    send_slow(8'h78); send_slow(8'h56); send_slow(8'h34); send_slow(8'h12);
    send_slow(8'hFF); send_slow(8'hFF); send_slow(8'h00);
    byte_in = 8'h00;
    tick(1);
    byte_stb = 1'b1;
    repeat (SYNC+1) @(posedge clk);
    #1;
    chk("latency_early", op_valid, 0);
    @(posedge clk);
    #1;
    chk("latency_valid", op_valid, 1);
    chk("issue_state", state_o, 2);
    #1;
    byte_stb = 1'b0;
    tick(2);
    chk("dir_op_a", op_a, 32'h12345678);
    chk("dir_op_b", op_b, 32'h0000FFFF);

    // Back-pressure then a single-cycle ready
    tick(20);
    chk("hold_valid", op_valid, 1);
    chk("hold_op_a", op_a, 32'h12345678);
    chk("hold_op_b", op_b, 32'h0000FFFF);
    op_ready = 1'b1;
    tick(1);
    op_ready = 1'b0;
    chk("hs_valid", op_valid, 0);
    chk("hs_state", state_o, 0);

    // Overrun in ISSUE, then abort with clr (this pair is never accepted)
    ra = $urandom; rb = $urandom;
    send_pair_slow(ra, rb);
    chk("ovr_pre_valid", op_valid, 1);
    send_slow(8'hAA);
    chk("ovr_flag", overrun, 1);
    chk("ovr_op_a", op_a, ra);
    chk("ovr_op_b", op_b, rb);
    clr = 1'b1;
    tick(SYNC+2);
    chk("clr_overrun", overrun, 0);
    chk("clr_state", state_o, 0);
    chk("clr_idx", byte_idx, 0);
    chk("clr_valid", op_valid, 0);
    chk("clr_op_a_hold", op_a, ra);
    send_slow(8'h55);
    chk("clr_stb_ignored", byte_idx, 0);
    clr = 1'b0;
    tick(SYNC+2);

    // Enable low in LOAD_B swallows strobes
    ra = $urandom; rb = $urandom;
    exp_q.push_back({ra, rb});
    for (int i = 0; i < NB; i++) send_slow(ra[8*i +: 8]);
    send_slow(rb[7:0]); send_slow(rb[15:8]);
    ena = 1'b0;
    for (int i = 0; i < 3; i++) send_slow(8'($urandom));
    chk("ena_idx", byte_idx, 2);
    chk("ena_state", state_o, 1);
    ena = 1'b1;
    tick(2);
    send_slow(rb[23:16]); send_slow(rb[31:24]);
    chk("ena_valid", op_valid, 1);
    wait_handshake();

    // Random pairs at minimum strobe spacing with random ready
    for (int p = 0; p < 12; p++) begin
      ra = $urandom; rb = $urandom;
      if (p == 0) ra = '1;
      if (p == 1) rb = '0;
      exp_q.push_back({ra, rb});
      send_pair_fast(ra, rb);
      chk("fast_valid", op_valid, 1);
      wait_handshake();
    end

    tick(5);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
